// File: rtl/jkc_pkg.sv
// rtl/jkc_pkg.sv - JK code constants and reverse-excitation function for the JK counter
//
// Contents:
//   JK_HOLD/JK_CLR/JK_SET/JK_TGL : 2-bit {J,K} drive codes (TGL is never generated)
//   jk_excite(q, q_next)         : {J,K} that moves a JK cell from q to q_next,
//                                  with every don't-care resolved to 0
package jkc_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // Resolving the don't-cares to 0 means a bit that stays put always
    // gets HOLD, so J and K are never high together.
    function automatic logic [1:0] jk_excite(input logic q, input logic q_next);
        logic [1:0] code;
        code = JK_HOLD;
        if (!q && q_next) begin
            code = JK_SET;
        end else if (q && !q_next) begin
            code = JK_CLR;
        end
        return code;
    endfunction

endpackage

// File: rtl/jk_excitation_counter_if.sv
// rtl/jk_excitation_counter_if.sv - control/status bundle of the JK excitation counter
//
// Signals (W bits wide where noted):
//   EN, UP, LOAD, DIN[W]  : counter controls, driven by the master
//   MOD_MAX[W]            : wrap point, only with JKC_MODULO_EN defined
//   Q[W], J[W], K[W]      : count and the J/K drive for the coming edge
//   TC, CARRY             : terminal count (combinational), wrap pulse (registered)
// Modports: master (control side), slave (counter side).
interface jk_excitation_counter_if #(
    parameter int W = 8
);
    logic         EN;
    logic         UP;
    logic         LOAD;
    logic [W-1:0] DIN;
`ifdef JKC_MODULO_EN
    logic [W-1:0] MOD_MAX;
`endif
    logic [W-1:0] Q;
    logic [W-1:0] J;
    logic [W-1:0] K;
    logic         TC;
    logic         CARRY;

    modport master (
        output EN, UP, LOAD, DIN,
`ifdef JKC_MODULO_EN
        output MOD_MAX,
`endif
        input  Q, J, K, TC, CARRY
    );

    modport slave (
        input  EN, UP, LOAD, DIN,
`ifdef JKC_MODULO_EN
        input  MOD_MAX,
`endif
        output Q, J, K, TC, CARRY
    );

endinterface

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single JK flip-flop storage cell
//
// Ports:
//   CLK : rising-edge clock
//   RST : synchronous active-high clear
//   J,K : 00 hold, 01 clear, 10 set, 11 toggle
//   Q   : stored bit
module jk_cell
    import jkc_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic J,
    input  logic K,
    output logic Q
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            Q <= 1'b0;
        end else begin
            case ({J, K})
                JK_CLR:  Q <= 1'b0;
                JK_SET:  Q <= 1'b1;
                JK_TGL:  Q <= ~Q;
                default: Q <= Q;
            endcase
        end
    end

endmodule

// File: rtl/jk_excitation_counter.sv
// rtl/jk_excitation_counter.sv - W-bit up/down counter stored in JK cells driven by reverse excitation
//
// Ports:
//   CLK, RST : rising-edge clock, synchronous active-high reset
//   bus      : jk_excitation_counter_if.slave (EN, UP, LOAD, DIN in; Q, J, K, TC, CARRY out)
// Parameter W (2..16) must match the interface width.
// Macro JKC_MODULO_EN: adds bus.MOD_MAX and uses it as the wrap point instead of 2^W-1.
module jk_excitation_counter
    import jkc_pkg::*;
#(
    parameter int W = 8
) (
    input logic                  CLK,
    input logic                  RST,
    jk_excitation_counter_if.slave bus
);

    logic [W-1:0] q;
    logic [W-1:0] top;
    logic [W-1:0] next_q;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic         tc;
    logic         carry;

`ifdef JKC_MODULO_EN
    assign top = bus.MOD_MAX;
`else
    assign top = '1;
`endif

    // Desired next count. RST is not decoded here: it clears the cells
    // directly and the excitation below is forced to hold.
    always_comb begin
        next_q = q;
        if (bus.LOAD) begin
            next_q = bus.DIN;
        end else if (bus.EN) begin
            if (bus.UP) begin
                // ">=" lets a loaded value above the modulus wrap to 0.
                next_q = (q >= top) ? '0 : q + 1'b1;
            end else begin
                next_q = (q == '0) ? top : q - 1'b1;
            end
        end
    end

    always_comb begin
        j = '0;
        k = '0;
        for (int i = 0; i < W; i++) begin
            {j[i], k[i]} = jk_excite(q[i], next_q[i]);
        end
        if (RST) begin
            j = '0;
            k = '0;
        end
    end

    for (genvar i = 0; i < W; i++) begin : g_cell
        jk_cell u_cell (
            .CLK (CLK),
            .RST (RST),
            .J   (j[i]),
            .K   (k[i]),
            .Q   (q[i])
        );
    end

    assign tc = bus.UP ? (q == top) : (q == '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            carry <= 1'b0;
        end else begin
            carry <= bus.EN && tc && !bus.LOAD;
        end
    end

    assign bus.Q     = q;
    assign bus.J     = j;
    assign bus.K     = k;
    assign bus.TC    = tc;
    assign bus.CARRY = carry;

endmodule

// File: tb/tb_jk_excitation_counter.sv
// tb/tb_jk_excitation_counter.sv - self-checking bench for jk_excitation_counter (W=8)
module tb_jk_excitation_counter;

    logic CLK = 1'b0;
    logic RST;
    int   passed = 0;
    int   total  = 0;
    int   mq;          // model count
    bit   mc;          // model carry

    jk_excitation_counter_if #(.W(8)) bus ();

    jk_excitation_counter #(.W(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    function automatic int top_val();
`ifdef JKC_MODULO_EN
        return int'(bus.MOD_MAX);
`else
        return 255;
`endif
    endfunction

    // Count sequence modulo (top+1); values above top only step down or jump to 0.
    function automatic int model_next(int q);
        int t;
        t = top_val();
        if (RST)       return 0;
        if (bus.LOAD)  return int'(bus.DIN);
        if (!bus.EN)   return q;
        if (bus.UP)    return (q > t) ? 0 : (q + 1) % (t + 1);
        return (q > t) ? q - 1 : (q + t) % (t + 1);
    endfunction

    function automatic bit model_tc();
        return bus.UP ? (mq == top_val()) : (mq == 0);
    endfunction

    // Bits rising need J, bits falling need K, nothing during reset.
    function automatic logic [7:0] model_j();
        logic [7:0] qv, nv;
        qv = mq[7:0];
        nv = 8'(model_next(mq));
        return RST ? 8'h00 : (~qv & nv);
    endfunction

    function automatic logic [7:0] model_k();
        logic [7:0] qv, nv;
        qv = mq[7:0];
        nv = 8'(model_next(mq));
        return RST ? 8'h00 : (qv & ~nv);
    endfunction

    task automatic tick();
        int n;
        bit c;
        n = model_next(mq);
        c = !RST && !bus.LOAD && bus.EN && model_tc();
        @(posedge CLK);
        #1;
        mq = n;
        mc = c;
    endtask

    task automatic set_ctl(bit rst, bit load, bit en, bit up, logic [7:0] din);
        RST = rst; bus.LOAD = load; bus.EN = en; bus.UP = up; bus.DIN = din;
        #1;
    endtask

    task automatic test_reset();
        set_ctl(1, 0, 0, 1, 8'h00);
        tick();
        tick();
        total++; if (bus.Q !== 8'h00) $display("FAIL reset_q: got %h want 00", bus.Q); else passed++;
        total++; if (bus.CARRY !== 1'b0) $display("FAIL reset_carry: got %b want 0", bus.CARRY); else passed++;
        total++; if (bus.TC !== 1'b0) $display("FAIL reset_tc_up: got %b want 0", bus.TC); else passed++;
        set_ctl(1, 0, 1, 1, 8'h00);
        total++; if (bus.J !== 8'h00 || bus.K !== 8'h00)
            $display("FAIL reset_jk: got J=%h K=%h want 00/00", bus.J, bus.K); else passed++;
        set_ctl(1, 0, 1, 0, 8'h00);
        total++; if (bus.TC !== 1'b1) $display("FAIL reset_tc_down: got %b want 1", bus.TC); else passed++;
        set_ctl(0, 0, 1, 1, 8'h00);
        total++; if (bus.J !== 8'h01 || bus.K !== 8'h00)
            $display("FAIL release_jk: got J=%h K=%h want 01/00", bus.J, bus.K); else passed++;
        tick();
        total++; if (bus.Q !== 8'h01) $display("FAIL release_q: got %h want 01", bus.Q); else passed++;
    endtask

    task automatic test_up_wrap();
        logic [7:0] exp_q [3];
        bit         exp_c [3];
        bit         exp_t [3];
        exp_q = '{8'hFF, 8'h00, 8'h01};
        exp_c = '{1'b0, 1'b1, 1'b0};
        exp_t = '{1'b0, 1'b1, 1'b0};
        set_ctl(0, 1, 0, 1, 8'hFE);
        tick();
        total++; if (bus.Q !== 8'hFE) $display("FAIL up_load: got %h want FE", bus.Q); else passed++;
        set_ctl(0, 0, 1, 1, 8'h00);
        for (int i = 0; i < 3; i++) begin
            total++; if (bus.TC !== exp_t[i]) $display("FAIL up_tc[%0d]: got %b want %b", i, bus.TC, exp_t[i]); else passed++;
            tick();
            total++; if (bus.Q !== exp_q[i]) $display("FAIL up_q[%0d]: got %h want %h", i, bus.Q, exp_q[i]); else passed++;
            total++; if (bus.CARRY !== exp_c[i]) $display("FAIL up_carry[%0d]: got %b want %b", i, bus.CARRY, exp_c[i]); else passed++;
        end
    endtask

    task automatic test_down_wrap();
        set_ctl(0, 1, 0, 0, 8'h01);
        tick();
        set_ctl(0, 0, 1, 0, 8'h00);
        tick();
        total++; if (bus.Q !== 8'h00 || bus.CARRY !== 1'b0)
            $display("FAIL down_q0: got Q=%h C=%b want 00/0", bus.Q, bus.CARRY); else passed++;
        total++; if (bus.TC !== 1'b1) $display("FAIL down_tc: got %b want 1", bus.TC); else passed++;
        tick();
        total++; if (bus.Q !== 8'hFF || bus.CARRY !== 1'b1)
            $display("FAIL down_wrap: got Q=%h C=%b want FF/1", bus.Q, bus.CARRY); else passed++;
    endtask

    task automatic test_excitation();
        set_ctl(0, 1, 0, 1, 8'h7F);
        tick();
        set_ctl(0, 0, 1, 1, 8'h00);
        total++; if (bus.J !== 8'h80 || bus.K !== 8'h7F)
            $display("FAIL exc_jk: got J=%h K=%h want 80/7F", bus.J, bus.K); else passed++;
        tick();
        total++; if (bus.Q !== 8'h80) $display("FAIL exc_q: got %h want 80", bus.Q); else passed++;
    endtask

    task automatic test_priority();
        set_ctl(0, 1, 0, 1, 8'hFF);
        tick();
        set_ctl(0, 1, 1, 1, 8'h55);
        total++; if (bus.TC !== 1'b1) $display("FAIL prio_tc: got %b want 1", bus.TC); else passed++;
        tick();
        total++; if (bus.Q !== 8'h55 || bus.CARRY !== 1'b0)
            $display("FAIL prio_load: got Q=%h C=%b want 55/0", bus.Q, bus.CARRY); else passed++;
        set_ctl(0, 1, 0, 1, 8'hFF);
        tick();
        set_ctl(1, 1, 1, 1, 8'h55);
        tick();
        total++; if (bus.Q !== 8'h00 || bus.CARRY !== 1'b0)
            $display("FAIL prio_rst: got Q=%h C=%b want 00/0", bus.Q, bus.CARRY); else passed++;
        // Hold at the wrap point.
        set_ctl(0, 1, 0, 1, 8'hFF);
        tick();
        set_ctl(0, 0, 0, 1, 8'h00);
        tick();
        tick();
        total++; if (bus.Q !== 8'hFF || bus.TC !== 1'b1 || bus.CARRY !== 1'b0)
            $display("FAIL hold_wrap: got Q=%h TC=%b C=%b want FF/1/0", bus.Q, bus.TC, bus.CARRY); else passed++;
    endtask

`ifdef JKC_MODULO_EN
    task automatic test_modulo();
        int carries;
        carries = 0;
        bus.MOD_MAX = 8'd9;
        set_ctl(1, 0, 0, 1, 8'h00);
        tick();
        set_ctl(0, 0, 1, 1, 8'h00);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.CARRY === 1'b1) carries++;
            total++; if (bus.Q !== 8'(i % 10)) $display("FAIL mod_up[%0d]: got %h want %h", i, bus.Q, 8'(i % 10)); else passed++;
        end
        total++; if (carries != 2) $display("FAIL mod_carries: got %0d want 2", carries); else passed++;
        set_ctl(0, 0, 1, 0, 8'h00);
        tick();
        total++; if (bus.Q !== 8'd9) $display("FAIL mod_down: got %h want 09", bus.Q); else passed++;
        set_ctl(0, 1, 0, 1, 8'd12);
        tick();
        set_ctl(0, 0, 1, 1, 8'h00);
        tick();
        total++; if (bus.Q !== 8'd0) $display("FAIL mod_above_up: got %h want 00", bus.Q); else passed++;
        set_ctl(0, 1, 0, 0, 8'd12);
        tick();
        set_ctl(0, 0, 1, 0, 8'h00);
        tick();
        total++; if (bus.Q !== 8'd11) $display("FAIL mod_above_down: got %h want 0B", bus.Q); else passed++;
        bus.MOD_MAX = 8'hFF;
    endtask
`endif

    task automatic test_random();
        logic [7:0] ej, ek;
        bit         et;
        for (int n = 0; n < 10000; n++) begin
`ifdef JKC_MODULO_EN
            if ($urandom_range(0, 63) == 0) bus.MOD_MAX = 8'($urandom_range(0, 255));
`endif
            set_ctl($urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom));
            ej = model_j();
            ek = model_k();
            et = model_tc();
            total++; if ((bus.J & bus.K) !== 8'h00) $display("FAIL rnd_jk_excl[%0d]: got %h want 00", n, bus.J & bus.K); else passed++;
            total++; if (bus.J !== ej || bus.K !== ek)
                $display("FAIL rnd_jk[%0d]: got J=%h K=%h want %h/%h", n, bus.J, bus.K, ej, ek); else passed++;
            total++; if (bus.TC !== et) $display("FAIL rnd_tc[%0d]: got %b want %b", n, bus.TC, et); else passed++;
            tick();
            total++; if (bus.Q !== 8'(mq)) $display("FAIL rnd_q[%0d]: got %h want %h", n, bus.Q, 8'(mq)); else passed++;
            total++; if (bus.CARRY !== mc) $display("FAIL rnd_carry[%0d]: got %b want %b", n, bus.CARRY, mc); else passed++;
        end
    endtask

    initial begin
        mq = 0;
        mc = 0;
`ifdef JKC_MODULO_EN
        bus.MOD_MAX = 8'hFF;
`endif
        set_ctl(1, 0, 0, 1, 8'h00);
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_excitation();
        test_priority();
`ifdef JKC_MODULO_EN
        test_modulo();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
